// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings plus a small op-classification helper.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_FIX  = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input mdu_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input mdu_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate, used both to take operand magnitudes
// and to restore the sign of the finished result.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO
// registers, with busy/done handshake, MTHI/MTLO writes and flush.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e state, state_next;
  mdu_op_e    op_q;
  mdu_op_e    op_in;

  logic [WIDTH-1:0]   divisor_or_mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CNT_W-1:0]   cnt;
  logic               res_neg;
  logic               rem_neg;
  logic               dbz_q;

  logic               issue;
  logic               in_div;
  logic               a_neg;
  logic               b_neg;
  logic               in_dbz;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  assign op_in  = mdu_op_e'(op);
  assign issue  = (state == MDU_IDLE) && start && !flush;
  assign in_div = op_is_div(op_in);
  assign a_neg  = op_is_signed(op_in) && src_a[WIDTH-1];
  assign b_neg  = op_is_signed(op_in) && src_b[WIDTH-1];
  assign in_dbz = in_div && (src_b == '0);
  assign busy   = (state != MDU_IDLE);

  mdu_sign_fix #(.W(WIDTH)) u_abs_a (.neg(a_neg), .din(src_a), .dout(abs_a));
  mdu_sign_fix #(.W(WIDTH)) u_abs_b (.neg(b_neg), .din(src_b), .dout(abs_b));

  // One radix-2 step of each algorithm; the RUN state picks one.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] div_next;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (acc[0] ? divisor_or_mcand : '0)};
  assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, divisor_or_mcand};
  assign div_ok    = ~div_diff[WIDTH];
  assign div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_ok};

  // Result correction; div-by-zero results are already final and skip it.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.neg(res_neg), .din(acc), .dout(prod_fix));
  mdu_sign_fix #(.W(WIDTH)) u_fix_quo (
    .neg(res_neg && !dbz_q), .din(acc[WIDTH-1:0]), .dout(quo_fix)
  );
  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (
    .neg(rem_neg && !dbz_q), .din(acc[2*WIDTH-1:WIDTH]), .dout(rem_fix)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      MDU_IDLE: if (issue) state_next = in_dbz ? MDU_FIX : MDU_RUN;
      MDU_RUN: begin
        if (flush)            state_next = MDU_IDLE;
        else if (cnt == '0)   state_next = MDU_FIX;
      end
      MDU_FIX:  state_next = MDU_IDLE;
      default:  state_next = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q             <= MDU_MULT;
      divisor_or_mcand <= '0;
      acc              <= '0;
      cnt              <= '0;
      res_neg          <= 1'b0;
      rem_neg          <= 1'b0;
      dbz_q            <= 1'b0;
      done             <= 1'b0;
      div_by_zero      <= 1'b0;
      hi               <= '0;
      lo               <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      unique case (state)
        MDU_IDLE: begin
          if (issue) begin
            op_q             <= op_in;
            cnt              <= CNT_W'(WIDTH - 1);
            res_neg          <= a_neg ^ b_neg;
            rem_neg          <= a_neg;
            dbz_q            <= in_dbz;
            divisor_or_mcand <= in_div ? abs_b : abs_a;
            if (in_dbz)      acc <= {src_a, {WIDTH{1'b1}}};
            else if (in_div) acc <= {{WIDTH{1'b0}}, abs_a};
            else             acc <= {{WIDTH{1'b0}}, abs_b};
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        MDU_RUN: begin
          if (!flush) begin
            acc <= op_is_div(op_q) ? div_next : mul_next;
            cnt <= cnt - CNT_W'(1);
          end
        end
        MDU_FIX: begin
          if (!flush) begin
            if (op_is_div(op_q)) begin
              hi <= rem_fix;
              lo <= quo_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            done        <= 1'b1;
            div_by_zero <= dbz_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
